single_port_ram_arbiter: RTL and testbench
==========================================

# single_port_ram_arbiter

Two-requester, round-robin arbiter and sequencer for `single_port_ram` (8-bit data, 6-bit address, single shared port, registered read).

- Each requester issues read or write transactions through a valid/ready handshake.
- The arbiter grants one transaction per cycle, drives the RAM port from registers and returns read data to the requester that issued the read.
- It sits between the two client blocks and the RAM instance; nothing else drives the RAM port.

## Interface
Parameters:
- `DATA_W`, 8, data width; matches RAM `data`/`q`.
- `ADDR_W`, 6, address width; matches RAM `addr`.
- `RD_LAT`, 1, RAM read latency: cycles from the RAM sampling `addr` (`we=0`) to `q` valid.

Ports:
- Clocking and reset (already decided): one clock; reset is synchronous and active-low.
  - `clk`  in  1  single clock; all state updates on its rising edge.
  - `rst_n`  in  1  synchronous, active-low reset; sampled on the rising edge of `clk`.
- Requester A:
  - `req_valid_a`  in  1  requester A has a transaction.
  - `req_we_a`  in  1  1 = write, 0 = read.
  - `req_addr_a`  in  ADDR_W  target address.
  - `req_wdata_a`  in  DATA_W  write data; ignored for reads.
  - `req_ready_a`  out  1  A's transaction is accepted this cycle.
  - `rsp_valid_a`  out  1  one-cycle pulse; `rsp_rdata_a` holds read data for A.
  - `rsp_rdata_a`  out  DATA_W  read data for A.
- Requester B: `req_valid_b`, `req_we_b`, `req_addr_b`, `req_wdata_b`, `req_ready_b`, `rsp_valid_b`, `rsp_rdata_b`; identical to A.
- RAM side:
  - `ram_addr`  out  ADDR_W  to RAM `addr`.
  - `ram_data`  out  DATA_W  to RAM `data`.
  - `ram_we`  out  1  to RAM `we`.
  - `ram_q`  in  DATA_W  from RAM `q`.

## Operation
- **Handshake:** a transaction transfers in any cycle where `req_valid_x && req_ready_x` at the rising edge.
  - Requester holds `valid`, `we`, `addr` and `wdata` stable until accepted.
  - `req_ready_x` is combinational from both `req_valid` inputs and the priority pointer.
  - At most one of `req_ready_a` / `req_ready_b` is high per cycle.
  - `req_ready_x` is never high when `req_valid_x` is low.
- **Arbitration:**
  - Only one valid: that requester is granted.
  - Both valid: the requester indicated by the priority pointer `prio` is granted.
  - `prio` (1 bit; 0 = A favoured) updates on every grant to favour the non-granted requester.
  - Neither valid: no grant; `prio` holds.
- **Issue:** on a grant, `ram_addr`, `ram_data` and `ram_we` register the granted `addr`, `wdata` and `we`.
  - Without a grant, `ram_we` registers 0; `ram_addr` and `ram_data` hold their previous values.
- **Read return:**
  - A pipeline of RD_LAT+1 stages tracks {read issued, owner} per issued transaction.
  - At its output, `rsp_rdata_owner` registers `ram_q` and `rsp_valid_owner` pulses for one cycle.
  - `rsp_rdata` of the non-owner holds its value.
- **Writes:** produce no response.
- **Ordering:** transactions execute in acceptance order. A read accepted after a write to the same address returns the new data.
- **Reset** (`rst_n` low at an edge):
  - Outputs: `ram_we`=0, `ram_addr`=0, `ram_data`=0, `rsp_valid_a`=`rsp_valid_b`=0, `rsp_rdata_a`=`rsp_rdata_b`=0.
  - Internal: `prio`=0 and the read pipeline is cleared.
  - `req_ready_a`/`req_ready_b` are forced low while `rst_n` is low.
  - Reads in flight at reset never produce `rsp_valid`.

## Timing
- Accept in cycle N → RAM port driven in cycle N+1 → RAM samples at the end of N+1 → `ram_q` valid in cycle N+1+RD_LAT.
- `rsp_valid`/`rsp_rdata` are valid in cycle N+RD_LAT+2 (cycle N+3 at default RD_LAT=1).
- Throughput: one transaction per cycle sustained, either mix of reads and writes.
- Back-to-back reads from alternating requesters return alternating responses on consecutive cycles.
- Under continuous contention, grants alternate A, B, A, B…; no requester waits more than one cycle.
- The first cycle after reset deasserts with both valid grants A.

## Test plan
- After reset: A writes 0x01@0, 0x02@1, 0x03@2 back-to-back.
  - Required: `req_ready_a` high 3 cycles; `ram_we`=1 with addr 0, 1, 2 in the following cycles.
- A reads @0, @1, @2 back-to-back.
  - Required: `rsp_valid_a` pulses at accept+3, accept+4, accept+5 with 0x01, 0x02, 0x03; `rsp_valid_b` stays 0.
- A and B both hold valid reads (A @1, B @2) for 4 cycles after reset.
  - Required: grants go A, B, A, B; responses return 0x02 to A and 0x03 to B, interleaved.
- B writes 0x04@1, then A reads @1 in the next cycle.
  - Required: A receives 0x04; `ram_we` high exactly 1 cycle.
- A reads @3 while B is idle.
  - Required: a single `rsp_valid_a` pulse; `rsp_rdata_b` unchanged.
- `rst_n` asserted low one cycle after A's read is accepted.
  - Required: no `rsp_valid_a`; `ram_we`=0 and both `ready` low during reset; `prio`=0 afterwards, so the first contended grant goes to A.

Source files
------------

// File: rtl/single_port_ram_arbiter.sv
// Round-robin arbiter and sequencer sharing one registered-read single-port RAM between
// two valid/ready requesters; read data is routed back to the requester that issued it.
module single_port_ram_arbiter #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 6,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid_a,
   input  logic              req_we_a,
   input  logic [ADDR_W-1:0] req_addr_a,
   input  logic [DATA_W-1:0] req_wdata_a,
   output logic              req_ready_a,
   output logic              rsp_valid_a,
   output logic [DATA_W-1:0] rsp_rdata_a,
   input  logic              req_valid_b,
   input  logic              req_we_b,
   input  logic [ADDR_W-1:0] req_addr_b,
   input  logic [DATA_W-1:0] req_wdata_b,
   output logic              req_ready_b,
   output logic              rsp_valid_b,
   output logic [DATA_W-1:0] rsp_rdata_b,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_data,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_q
);

   typedef enum logic {OWN_A = 1'b0, OWN_B = 1'b1} owner_e;

   typedef struct packed {
      logic   rd;
      owner_e owner;
   } track_t;

   localparam int STAGES = RD_LAT + 1;

   owner_e            prio;
   logic              grant_a;
   logic              grant_b;
   logic              grant;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   track_t            pipe [STAGES];
   track_t            last;
   logic              ret_a;
   logic              ret_b;

   // Grant is combinational so a lone requester is accepted in the cycle it asserts valid.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, otherwise any
      // path that skips an assignment infers a latch.
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (rst_n) begin
         if (req_valid_a && req_valid_b) begin
            grant_a = (prio == OWN_A);
            grant_b = (prio == OWN_B);
         end else begin
            grant_a = req_valid_a;
            grant_b = req_valid_b;
         end
      end
   end

   assign grant       = grant_a || grant_b;
   assign req_ready_a = grant_a;
   assign req_ready_b = grant_b;

   always_comb begin
      sel_we    = req_we_a;
      sel_addr  = req_addr_a;
      sel_wdata = req_wdata_a;
      if (grant_b) begin
         sel_we    = req_we_b;
         sel_addr  = req_addr_b;
         sel_wdata = req_wdata_b;
      end
   end

   // RAM port and priority pointer; addr/data hold when idle, only we drops.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prio     <= OWN_A;
         ram_we   <= 1'b0;
         ram_addr <= '0;
         ram_data <= '0;
      end else if (grant) begin
         // NOTE: state is updated with non-blocking assignments so every register samples
         // pre-edge values regardless of statement order.
         prio     <= grant_a ? OWN_B : OWN_A;
         ram_we   <= sel_we;
         ram_addr <= sel_addr;
         ram_data <= sel_wdata;
      end else begin
         ram_we   <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         // NOTE: the tracking pipeline is reset, unlike a data memory, because a stale
         // entry would emit a spurious response after reset.
         for (int i = 0; i < STAGES; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= '{rd: grant && !sel_we, owner: (grant_b ? OWN_B : OWN_A)};
         for (int i = 1; i < STAGES; i++) pipe[i] <= pipe[i-1];
      end
   end

   // The last stage lines up with ram_q being valid for that read.
   assign last  = pipe[STAGES-1];
   assign ret_a = last.rd && (last.owner == OWN_A);
   assign ret_b = last.rd && (last.owner == OWN_B);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rsp_valid_a <= 1'b0;
         rsp_valid_b <= 1'b0;
         rsp_rdata_a <= '0;
         rsp_rdata_b <= '0;
      end else begin
         rsp_valid_a <= ret_a;
         rsp_valid_b <= ret_b;
         if (ret_a) rsp_rdata_a <= ram_q;
         if (ret_b) rsp_rdata_b <= ram_q;
      end
   end

endmodule

// File: tb/tb_single_port_ram_arbiter.sv
// Bench for single_port_ram_arbiter: a behavioural RAM, a transaction-level reference
// model checked every cycle, directed scenarios with literal expectations, then random traffic.
module tb_single_port_ram_arbiter;

   localparam int DW     = 8;
   localparam int AW     = 6;
   localparam int RD_LAT = 1;
   localparam int DEPTH  = 2 ** AW;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid_a, req_we_a, req_ready_a, rsp_valid_a;
   logic [AW-1:0] req_addr_a;
   logic [DW-1:0] req_wdata_a, rsp_rdata_a;
   logic          req_valid_b, req_we_b, req_ready_b, rsp_valid_b;
   logic [AW-1:0] req_addr_b;
   logic [DW-1:0] req_wdata_b, rsp_rdata_b;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_data, ram_q;
   logic          ram_we;

   always #5 clk = ~clk;

   single_port_ram_arbiter #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(RD_LAT)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid_a (req_valid_a),
      .req_we_a    (req_we_a),
      .req_addr_a  (req_addr_a),
      .req_wdata_a (req_wdata_a),
      .req_ready_a (req_ready_a),
      .rsp_valid_a (rsp_valid_a),
      .rsp_rdata_a (rsp_rdata_a),
      .req_valid_b (req_valid_b),
      .req_we_b    (req_we_b),
      .req_addr_b  (req_addr_b),
      .req_wdata_b (req_wdata_b),
      .req_ready_b (req_ready_b),
      .rsp_valid_b (rsp_valid_b),
      .rsp_rdata_b (rsp_rdata_b),
      .ram_addr    (ram_addr),
      .ram_data    (ram_data),
      .ram_we      (ram_we),
      .ram_q       (ram_q)
   );

   // Single-port RAM with registered read of RD_LAT cycles.
   logic [DW-1:0] ram_mem [DEPTH];
   logic [DW-1:0] q_pipe  [RD_LAT];

   always @(posedge clk) begin
      if (ram_we) ram_mem[ram_addr] <= ram_data;
      q_pipe[0] <= ram_mem[ram_addr];
      for (int i = 1; i < RD_LAT; i++) q_pipe[i] <= q_pipe[i-1];
   end
   assign ram_q = q_pipe[RD_LAT-1];

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int we_cycles = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_checks++;
      if (act !== want)
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, want, cyc);
      else
         n_pass++;
   endtask

   // Reference model: transactions take effect in acceptance order; each accepted read
   // is answered RD_LAT+2 cycles later with the memory contents as of its acceptance.
   typedef struct { int due; bit owner; logic [DW-1:0] data; } rsp_t;
   typedef struct { int cyc; bit owner; logic [DW-1:0] data; } obs_t;

   rsp_t          exp_q [$];
   obs_t          log_q [$];
   logic [DW-1:0] model_mem [DEPTH];
   bit            m_prio_b;
   logic          m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data, m_rdata_a, m_rdata_b;

   initial begin
      bit            ea, eb, va, vb, winner_b, g_we;
      logic [AW-1:0] g_addr;
      logic [DW-1:0] g_data;
      rsp_t          r;
      m_prio_b  = 1'b0;
      m_we      = 1'b0;
      m_addr    = '0;
      m_data    = '0;
      m_rdata_a = '0;
      m_rdata_b = '0;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
      repeat (2) @(posedge clk);
      forever begin
         @(negedge clk);
         ea = 1'b0;
         eb = 1'b0;
         winner_b = 1'b0;
         if (rst_n === 1'b1 && (req_valid_a || req_valid_b)) begin
            winner_b = (req_valid_a && req_valid_b) ? m_prio_b : req_valid_b;
            ea = !winner_b;
            eb = winner_b;
         end
         va = 1'b0;
         vb = 1'b0;
         if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            r = exp_q.pop_front();
            if (r.owner) begin vb = 1'b1; m_rdata_b = r.data; end
            else         begin va = 1'b1; m_rdata_a = r.data; end
         end
         check("ready_a", req_ready_a, ea);
         check("ready_b", req_ready_b, eb);
         check("ram_we", ram_we, m_we);
         check("ram_addr", ram_addr, m_addr);
         check("ram_data", ram_data, m_data);
         check("rsp_valid_a", rsp_valid_a, va);
         check("rsp_valid_b", rsp_valid_b, vb);
         check("rsp_rdata_a", rsp_rdata_a, m_rdata_a);
         check("rsp_rdata_b", rsp_rdata_b, m_rdata_b);
         if (ram_we === 1'b1) we_cycles++;
         if (rsp_valid_a === 1'b1) log_q.push_back('{cyc, 1'b0, rsp_rdata_a});
         if (rsp_valid_b === 1'b1) log_q.push_back('{cyc, 1'b1, rsp_rdata_b});
         if (rst_n !== 1'b1) begin
            exp_q.delete();
            m_prio_b  = 1'b0;
            m_we      = 1'b0;
            m_addr    = '0;
            m_data    = '0;
            m_rdata_a = '0;
            m_rdata_b = '0;
         end else if (ea || eb) begin
            g_we   = winner_b ? req_we_b    : req_we_a;
            g_addr = winner_b ? req_addr_b  : req_addr_a;
            g_data = winner_b ? req_wdata_b : req_wdata_a;
            m_we   = g_we;
            m_addr = g_addr;
            m_data = g_data;
            m_prio_b = !winner_b;
            if (g_we) model_mem[g_addr] = g_data;
            else exp_q.push_back('{cyc + RD_LAT + 2, winner_b, model_mem[g_addr]});
         end else begin
            m_we = 1'b0;
         end
      end
   end

   task automatic set_a(input int v, input int we, input int addr, input int data);
      req_valid_a = (v != 0);
      req_we_a    = (we != 0);
      req_addr_a  = AW'(addr);
      req_wdata_a = DW'(data);
   endtask

   task automatic set_b(input int v, input int we, input int addr, input int data);
      req_valid_b = (v != 0);
      req_we_b    = (we != 0);
      req_addr_b  = AW'(addr);
      req_wdata_b = DW'(data);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_rsp(input string name, input int idx, input int at, input int owner,
                             input int data);
      if (idx < log_q.size()) begin
         check({name, "_cycle"}, log_q[idx].cyc, at);
         check({name, "_owner"}, {31'd0, log_q[idx].owner}, owner);
         check({name, "_data"}, {24'd0, log_q[idx].data}, data);
      end else begin
         check({name, "_present"}, 0, 1);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin
      int t0, n0, w0;
      bit acc_a, acc_b;
      for (int i = 0; i < DEPTH; i++) ram_mem[i] = '0;
      rst_n = 1'b0;
      set_a(0, 0, 0, 0);
      set_b(0, 0, 0, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_ram_we", ram_we, 0);
      check("reset_ram_addr", ram_addr, 0);
      check("reset_rsp_valid_a", rsp_valid_a, 0);
      check("reset_rsp_rdata_b", rsp_rdata_b, 0);
      tick();
      rst_n = 1'b1;

      // A writes 0x01@0, 0x02@1, 0x03@2 back-to-back.
      for (int i = 0; i < 3; i++) begin
         set_a(1, 1, i, i + 1);
         @(negedge clk);
         check("wr_ready_a", req_ready_a, 1);
         if (i > 0) begin
            check("wr_ram_we", ram_we, 1);
            check("wr_ram_addr", ram_addr, i - 1);
         end
         tick();
      end
      set_a(0, 0, 0, 0);
      @(negedge clk);
      check("wr_ram_we_last", ram_we, 1);
      check("wr_ram_addr_last", ram_addr, 2);
      check("wr_ram_data_last", ram_data, 3);
      repeat (3) tick();

      // A reads @0, @1, @2 back-to-back.
      n0 = log_q.size();
      for (int i = 0; i < 3; i++) begin
         set_a(1, 0, i, 0);
         @(negedge clk);
         if (i == 0) t0 = cyc;
         tick();
      end
      set_a(0, 0, 0, 0);
      repeat (6) tick();
      check("rd_count", log_q.size() - n0, 3);
      for (int k = 0; k < 3; k++) expect_rsp("rd_seq", n0 + k, t0 + 3 + k, 0, k + 1);

      // Reset, then A@1 and B@2 both hold valid reads for 4 cycles.
      rst_n = 1'b0;
      set_a(1, 0, 1, 0);
      set_b(1, 0, 2, 0);
      @(negedge clk);
      check("rst_ready_a", req_ready_a, 0);
      check("rst_ready_b", req_ready_b, 0);
      tick();
      rst_n = 1'b1;
      n0 = log_q.size();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i == 0) t0 = cyc;
         check("rr_ready_a", req_ready_a, (i % 2 == 0) ? 1 : 0);
         check("rr_ready_b", req_ready_b, (i % 2 == 1) ? 1 : 0);
         tick();
      end
      set_a(0, 0, 0, 0);
      set_b(0, 0, 0, 0);
      repeat (6) tick();
      check("rr_count", log_q.size() - n0, 4);
      for (int k = 0; k < 4; k++)
         expect_rsp("rr_seq", n0 + k, t0 + 3 + k, k % 2, (k % 2 == 0) ? 2 : 3);

      // B writes 0x04@1, A reads @1 in the next cycle.
      n0 = log_q.size();
      w0 = we_cycles;
      set_b(1, 1, 1, 4);
      @(negedge clk);
      check("raw_ready_b", req_ready_b, 1);
      tick();
      set_b(0, 0, 0, 0);
      set_a(1, 0, 1, 0);
      @(negedge clk);
      t0 = cyc;
      check("raw_ready_a", req_ready_a, 1);
      tick();
      set_a(0, 0, 0, 0);
      repeat (6) tick();
      check("raw_we_cycles", we_cycles - w0, 1);
      check("raw_count", log_q.size() - n0, 1);
      expect_rsp("raw", n0, t0 + 3, 0, 4);

      // A reads @3 while B is idle.
      set_b(1, 1, 3, 8'h5A);
      tick();
      set_b(0, 0, 0, 0);
      tick();
      n0 = log_q.size();
      set_a(1, 0, 3, 0);
      @(negedge clk);
      t0 = cyc;
      tick();
      set_a(0, 0, 0, 0);
      repeat (6) tick();
      check("solo_count", log_q.size() - n0, 1);
      expect_rsp("solo", n0, t0 + 3, 0, 8'h5A);
      check("solo_rdata_b_held", rsp_rdata_b, 3);

      // Reset one cycle after A's read is accepted.
      n0 = log_q.size();
      set_a(1, 0, 2, 0);
      @(negedge clk);
      t0 = cyc;
      check("flush_ready_a", req_ready_a, 1);
      tick();
      rst_n = 1'b0;
      set_a(1, 0, 0, 0);
      set_b(1, 0, 1, 0);
      @(negedge clk);
      check("flush_rst_ready_a", req_ready_a, 0);
      check("flush_rst_ready_b", req_ready_b, 0);
      tick();
      @(negedge clk);
      check("flush_rst_ram_we", ram_we, 0);
      check("flush_rst_ready_a2", req_ready_a, 0);
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      check("flush_first_ready_a", req_ready_a, 1);
      check("flush_first_ready_b", req_ready_b, 0);
      tick();
      set_a(0, 0, 0, 0);
      set_b(0, 0, 0, 0);
      repeat (6) tick();
      check("flush_count", log_q.size() - n0, 1);
      expect_rsp("flush", n0, t0 + 6, 0, 1);

      // Random traffic; requests hold until accepted, with occasional resets.
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         acc_a = req_valid_a && req_ready_a;
         acc_b = req_valid_b && req_ready_b;
         @(posedge clk);
         #1;
         rst_n = ($urandom_range(0, 249) != 0);
         if (!req_valid_a || acc_a)
            set_a(($urandom_range(0, 3) != 0) ? 1 : 0, $urandom_range(0, 1),
                  $urandom_range(0, 7), $urandom_range(0, 255));
         if (!req_valid_b || acc_b)
            set_b(($urandom_range(0, 3) != 0) ? 1 : 0, $urandom_range(0, 1),
                  $urandom_range(0, 7), $urandom_range(0, 255));
      end
      rst_n = 1'b1;
      set_a(0, 0, 0, 0);
      set_b(0, 0, 0, 0);
      repeat (8) tick();
      check("drain_pending", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
